midi_tx: RTL and testbench

- Transmit-side counterpart of the MIDI receive path.
- Accepts one complete MIDI channel or real-time message per handshake: a status byte plus up to two data bytes.
- Validates the message, works out its length from the status byte, and serializes the bytes as MIDI UART frames on `tx`.
- Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity, at BAUD.

---
 rtl/midi_tx.sv | 163 ++++++++++++++++
 tb/tb_midi_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// MIDI transmitter: validates one channel/real-time message and serializes it as 8N1 frames on tx.
// Optional running-status suppression is enabled with `define MIDI_RUNNING_STATUS_EN.
module midi_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] status_in,
  input  logic [7:0] data1_in,
  input  logic [7:0] data2_in,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(8);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("midi_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_BITS, S_STOP, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [1:0]       rem;
  logic             bit_done;

  logic [7:0] status_r, data1_r, data2_r;
  logic [7:0] shreg, seq1, seq2;

  logic [1:0] msg_len, rem_init;
  logic       reject;
  logic [7:0] first_byte, seq1_init, seq2_init;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       is_chan;
  assign is_chan = status_r[7] && (status_r[7:4] != 4'hF);
`endif

  assign bit_done  = (cnt == '0);
  assign msg_ready = (state == S_IDLE);

  // Decode of the captured message: length, validity and byte order
  always_comb begin
    msg_len = 2'd3;
    reject  = 1'b0;
    if (!status_r[7])                      reject  = 1'b1;
    else if (status_r[7:3] == 5'b11110)    reject  = 1'b1;
    else if (status_r[7:3] == 5'b11111)    msg_len = 2'd1;
    else if (status_r[7:5] == 3'b110)      msg_len = 2'd2;
    if ((msg_len >= 2'd2) && data1_r[7])   reject  = 1'b1;
    if ((msg_len == 2'd3) && data2_r[7])   reject  = 1'b1;

    first_byte = status_r;
    seq1_init  = data1_r;
    seq2_init  = data2_r;
    rem_init   = msg_len - 2'd1;
`ifdef MIDI_RUNNING_STATUS_EN
    if (is_chan && (status_r == last_status)) begin
      first_byte = data1_r;
      seq1_init  = data2_r;
      rem_init   = msg_len - 2'd2;
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (msg_valid) state_nx = S_CHECK;
      S_CHECK: state_nx = reject ? S_ERR : S_START;
      S_START: if (bit_done) state_nx = S_BITS;
      S_BITS:  if (bit_done && (bit_idx == IDX_W'(7))) state_nx = S_STOP;
      S_STOP:  if (bit_done) state_nx = (rem != 2'd0) ? S_START : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control: state, bit timing and remaining-byte count
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= CNT_MAX;
      bit_idx <= '0;
      rem     <= 2'd0;
    end else begin
      state <= state_nx;
      if ((state inside {S_START, S_BITS, S_STOP}) && !bit_done)
        cnt <= cnt - CNT_W'(1);
      else
        cnt <= CNT_MAX;
      if (state == S_START)
        bit_idx <= '0;
      else if ((state == S_BITS) && bit_done)
        bit_idx <= bit_idx + IDX_W'(1);
      if (state == S_CHECK)
        rem <= rem_init;
      else if ((state == S_STOP) && bit_done && (rem != 2'd0))
        rem <= rem - 2'd1;
    end
  end

  // Data path: message capture and shift register; the next byte loads on the last stop cycle
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && msg_valid) begin
      status_r <= status_in;
      data1_r  <= data1_in;
      data2_r  <= data2_in;
    end
    if (state == S_CHECK) begin
      shreg <= first_byte;
      seq1  <= seq1_init;
      seq2  <= seq2_init;
    end else if ((state == S_BITS) && bit_done) begin
      shreg <= {1'b0, shreg[7:1]};
    end else if ((state == S_STOP) && bit_done && (rem != 2'd0)) begin
      shreg <= seq1;
      seq1  <= seq2;
    end
  end

  // Registered outputs, one cycle behind the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      tx    <= (state == S_START) ? 1'b0 : ((state == S_BITS) ? shreg[0] : 1'b1);
      busy  <= ((state == S_CHECK) && !reject) || (state inside {S_START, S_BITS, S_STOP});
      done  <= (state == S_DONE);
      error <= (state == S_ERR);
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_status <= 8'h00;
    else if ((state == S_CHECK) && !reject && is_chan)
      last_status <= status_r;
  end
`endif

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: directed plan steps plus random messages against a byte-level model.
module tb_midi_tx;
  localparam int CLK_FREQ = 312500;
  localparam int BAUD     = 31250;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_valid = 1'b0;
  logic [7:0] status_in = 8'h00;
  logic [7:0] data1_in  = 8'h00;
  logic [7:0] data2_in  = 8'h00;
  logic       msg_ready, tx, busy, done, error;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_last = 8'h00;
  logic [7:0] exp_q[$];
  bit         exp_rej;

  midi_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .status_in(status_in), .data1_in(data1_in), .data2_in(data2_in),
    .tx(tx), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Message model: list of bytes that should appear on the line, or a reject.
  task automatic model(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
    int len;
    int s;
    s = st;
    exp_q.delete();
    exp_rej = 1'b0;
    len = 3;
    if (s < 128 || (s >= 240 && s <= 247)) exp_rej = 1'b1;
    else if (s >= 248) len = 1;
    else if (s >= 192 && s <= 223) len = 2;
    if (!exp_rej && len >= 2 && d1 >= 128) exp_rej = 1'b1;
    if (!exp_rej && len == 3 && d2 >= 128) exp_rej = 1'b1;
    if (exp_rej) return;
    exp_q.push_back(st);
    if (len >= 2) exp_q.push_back(d1);
    if (len == 3) exp_q.push_back(d2);
`ifdef MIDI_RUNNING_STATUS_EN
    if (s < 240) begin
      if (st == model_last) void'(exp_q.pop_front());
      else model_last = st;
    end
`endif
  endtask

  function automatic logic exp_tx_at(int j);
    int t, b, byt, pos;
    logic [7:0] v;
    t = j - 2;
    if (t < 0 || t >= 10 * exp_q.size() * CPB) return 1'b1;
    b   = t / CPB;
    byt = b / 10;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    v = exp_q[byt];
    return v[pos-1];
  endfunction

  // Hand one message over and follow every cycle until done (or the error pulse).
  task automatic run_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                         input bit hold, input string tag);
    int guard, n, span, len_cycles;
    int e_tx, e_busy, e_done, e_rdy, e_err;
    model(st, d1, d2);
    n = exp_q.size();
    span = 10 * n * CPB;
    guard = 0;
    while (msg_ready !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    chk({tag, "_ready_wait"}, {31'd0, msg_ready}, 32'd1);
    msg_valid = 1'b1;
    status_in = st;
    data1_in  = d1;
    data2_in  = d2;
    tick();
    if (!hold) msg_valid = 1'b0;
    status_in = 8'($urandom);
    data1_in  = 8'($urandom);
    data2_in  = 8'($urandom);
    len_cycles = exp_rej ? 3 : span + 2;
    e_tx = 0; e_busy = 0; e_done = 0; e_rdy = 0; e_err = 0;
    for (int j = 1; j <= len_cycles; j++) begin
      tick();
      if (tx !== exp_tx_at(j)) e_tx++;
      if (busy !== (!exp_rej && j <= span + 1)) e_busy++;
      if (done !== (!exp_rej && j == span + 2)) e_done++;
      if (error !== (exp_rej && j == 2)) e_err++;
      if (msg_ready !== (exp_rej ? (j >= 2) : (j == span + 2))) e_rdy++;
      if (hold) begin
        status_in = 8'($urandom);
        data1_in  = 8'($urandom);
        data2_in  = 8'($urandom);
      end
    end
    chk({tag, "_tx_bad_cycles"},    e_tx,   0);
    chk({tag, "_busy_bad_cycles"},  e_busy, 0);
    chk({tag, "_done_bad_cycles"},  e_done, 0);
    chk({tag, "_error_bad_cycles"}, e_err,  0);
    chk({tag, "_ready_bad_cycles"}, e_rdy,  0);
  endtask

  initial begin
    logic [7:0] st, d1, d2, prev_st;
    int e_tx, e_busy, e_done;

    rst = 1'b1;
    tick();
    tick();
    chk("reset_tx",    {31'd0, tx},        32'd1);
    chk("reset_busy",  {31'd0, busy},      32'd0);
    chk("reset_done",  {31'd0, done},      32'd0);
    chk("reset_error", {31'd0, error},     32'd0);
    chk("reset_ready", {31'd0, msg_ready}, 32'd1);
    rst = 1'b0;
    tick();

    run_msg(8'h90, 8'h3C, 8'h64, 1'b0, "note_on");
    run_msg(8'hC5, 8'h07, 8'hFF, 1'b0, "prog_change");
    run_msg(8'hF8, 8'h00, 8'h00, 1'b0, "realtime");
    run_msg(8'h3C, 8'h00, 8'h00, 1'b0, "rej_status_msb");
    run_msg(8'hF2, 8'h01, 8'h02, 1'b0, "rej_system");
    run_msg(8'h90, 8'h80, 8'h00, 1'b0, "rej_data_msb");

    run_msg(8'h90, 8'h3C, 8'h64, 1'b0, "rs_first");
    run_msg(8'h90, 8'h3E, 8'h00, 1'b0, "rs_repeat");
    run_msg(8'h80, 8'h3C, 8'h00, 1'b0, "rs_other");

    // Reset during bit 4 of the second byte of a note-on
    msg_valid = 1'b1;
    status_in = 8'h90;
    data1_in  = 8'h3C;
    data2_in  = 8'h64;
    tick();
    msg_valid = 1'b0;
    for (int j = 1; j <= 155; j++) tick();
    chk("midreset_pre_tx", {31'd0, tx}, 32'd1);
    chk("midreset_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 8'h00;
    chk("midreset_tx",    {31'd0, tx},        32'd1);
    chk("midreset_busy",  {31'd0, busy},      32'd0);
    chk("midreset_ready", {31'd0, msg_ready}, 32'd1);
    e_tx = 0; e_busy = 0; e_done = 0;
    for (int j = 0; j < 320; j++) begin
      tick();
      if (tx !== 1'b1) e_tx++;
      if (busy !== 1'b0) e_busy++;
      if (done !== 1'b0) e_done++;
    end
    chk("midreset_idle_tx",   e_tx,   0);
    chk("midreset_idle_busy", e_busy, 0);
    chk("midreset_no_done",   e_done, 0);
    run_msg(8'hFA, 8'h00, 8'h00, 1'b0, "after_reset_rt");

    // Valid held high with changing buses; next message accepted in the done cycle
    run_msg(8'h90, 8'h40, 8'h7F, 1'b1, "held_first");
    run_msg(8'hB0, 8'h07, 8'h64, 1'b0, "held_second");

    prev_st = 8'h90;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    st = 8'h80 | 8'($urandom_range(0, 63));
        2:       st = 8'hE0 | 8'($urandom_range(0, 15));
        3:       st = 8'hC0 | 8'($urandom_range(0, 31));
        4:       st = 8'hF8 | 8'($urandom_range(0, 7));
        default: st = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) st = prev_st;
      d1 = 8'($urandom_range(0, 127));
      d2 = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) d1 = d1 | 8'h80;
      if ($urandom_range(0, 7) == 0) d2 = d2 | 8'h80;
      prev_st = st;
      run_msg(st, d1, d2, 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
